// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath: FSM states,
// operation modes and a helper for sizing step counters.
package calc_pkg;

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      CALCULO  = 2'd1,
      LISTO    = 2'd2
   } estado_t;

   localparam logic MODO_SUMA  = 1'b0;
   localparam logic MODO_RESTA = 1'b1;

   // A single-step operation still needs a one-bit counter to hold a value.
   function automatic int ancho_cnt(input int pasos);
      return (pasos > 1) ? $clog2(pasos) : 1;
   endfunction

endpackage

// File: rtl/sumador_bloque.sv
// Combinational BLOQUE-bit full adder used once per step by the sequential
// adder/subtractor; also exposes the carry into its top bit for overflow.
module sumador_bloque #(
   parameter int BLOQUE = 2
) (
   input  logic [BLOQUE-1:0] a,
   input  logic [BLOQUE-1:0] b,
   input  logic              cin,
   output logic [BLOQUE-1:0] s,
   output logic              cout,
   output logic              c_msb
);

   logic [BLOQUE:0] w_suma;

   assign w_suma = {1'b0, a} + {1'b0, b} + {{BLOQUE{1'b0}}, cin};
   assign s      = w_suma[BLOQUE-1:0];
   assign cout   = w_suma[BLOQUE];
   // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out for free.
   assign c_msb  = a[BLOQUE-1] ^ b[BLOQUE-1] ^ w_suma[BLOQUE-1];

endmodule

// File: rtl/suma_resta_secuencial.sv
// Multi-cycle ANCHO-bit adder/subtractor: BLOQUE bits per clock through a
// registered carry, with valid/ready handshakes on both sides.
module suma_resta_secuencial #(
   parameter int ANCHO  = 8,
   parameter int BLOQUE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ANCHO-1:0] a,
   input  logic [ANCHO-1:0] b,
   input  logic             modo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ANCHO:0]   x,
   output logic             desborde
);

   import calc_pkg::*;

   localparam int PASOS = ANCHO / BLOQUE;
   localparam int CW    = ancho_cnt(PASOS);

   generate
      if (BLOQUE < 1 || BLOQUE > ANCHO || (ANCHO % BLOQUE) != 0) begin : g_param_err
         $error("suma_resta_secuencial: ANCHO must be a multiple of BLOQUE, 1 <= BLOQUE <= ANCHO");
      end
   endgenerate

   estado_t           r_estado;
   logic [ANCHO-1:0]  r_a;
   logic [ANCHO-1:0]  r_b;
   logic              r_modo;
   logic              r_carry;
   logic [CW-1:0]     r_cnt;
   logic [ANCHO:0]    r_x;
   logic              r_desborde;
   logic              r_in_ready;
   logic              r_out_valid;

   logic [31:0]       w_base;
   logic [BLOQUE-1:0] w_a_sl;
   logic [BLOQUE-1:0] w_b_sl;
   logic [BLOQUE-1:0] w_s;
   logic              w_cout;
   logic              w_cmsb;
   logic              w_ultimo;

   assign w_base   = 32'(r_cnt) * 32'(BLOQUE);
   assign w_a_sl   = r_a[w_base +: BLOQUE];
   assign w_b_sl   = r_b[w_base +: BLOQUE];
   assign w_ultimo = (r_cnt == CW'(PASOS - 1));

   sumador_bloque #(.BLOQUE(BLOQUE)) u_sumador (
      .a     (w_a_sl),
      .b     (w_b_sl),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout),
      .c_msb (w_cmsb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_estado    <= INACTIVO;
         r_a         <= '0;
         r_b         <= '0;
         r_modo      <= 1'b0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_x         <= '0;
         r_desborde  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_estado)
            INACTIVO: begin
               // Subtraction is A + ~B + 1: invert B once here, seed the carry with modo.
               if (r_in_ready && in_valid) begin
                  r_a        <= a;
                  r_b        <= b ^ {ANCHO{modo}};
                  r_modo     <= modo;
                  r_carry    <= modo;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_estado   <= CALCULO;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            CALCULO: begin
               r_x[w_base +: BLOQUE] <= w_s;
               r_carry               <= w_cout;
               r_cnt                 <= r_cnt + 1'b1;
               if (w_ultimo) begin
                  r_x[ANCHO]  <= (r_modo == MODO_RESTA) ? ~w_cout : w_cout;
                  r_desborde  <= w_cmsb ^ w_cout;
                  r_out_valid <= 1'b1;
                  r_estado    <= LISTO;
               end
            end
            LISTO: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_estado    <= INACTIVO;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
               r_estado    <= INACTIVO;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign x         = r_x;
   assign desborde  = r_desborde;

endmodule

// File: tb/tb_suma_resta_secuencial.sv
// Bench for suma_resta_secuencial: four parameterisations driven with directed
// and random operations, compared against an arithmetic reference model.
module tb_suma_resta_secuencial;

   function automatic int an(input int k);
      case (k)
         0: return 8;
         1: return 5;
         2: return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int bl(input int k);
      case (k)
         0: return 2;
         1: return 1;
         2: return 8;
         default: return 4;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  modo;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [3:0]  desb;
   logic [15:0] a_s [4];
   logic [15:0] b_s [4];
   logic [16:0] x_s [4];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [an(g):0] w_x;
      suma_resta_secuencial #(.ANCHO(an(g)), .BLOQUE(bl(g))) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a         (a_s[g][an(g)-1:0]),
         .b         (b_s[g][an(g)-1:0]),
         .modo      (modo[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .x         (w_x),
         .desborde  (desb[g])
      );
      assign x_s[g] = 17'(w_x);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: {overflow, carry/borrow, ANCHO-bit result} from plain integer arithmetic.
   function automatic logic [17:0] modelo(input int w, input longint va, input longint vb, input bit m);
      longint m2, r, low, sa, sb, sr, xv;
      bit     cb, ovf;
      logic [63:0] xb;
      m2 = longint'(1) << w;
      if (!m) begin
         r  = va + vb;
         cb = (r >= m2);
      end else begin
         r  = va - vb;
         cb = (va < vb);
      end
      low = ((r % m2) + m2) % m2;
      sa  = (va >= m2 / 2) ? va - m2 : va;
      sb  = (vb >= m2 / 2) ? vb - m2 : vb;
      sr  = m ? sa - sb : sa + sb;
      ovf = (sr < -(m2 / 2)) || (sr >= m2 / 2);
      xv  = (cb ? m2 : 0) + low;
      xb  = 64'(xv);
      return {ovf, xb[16:0]};
   endfunction

   // Runs one operation on instance k starting at a falling edge; ends at a falling edge.
   task automatic run_op(input int k, input logic [15:0] va, input logic [15:0] vb,
                         input bit vm, input int hold,
                         output logic [16:0] got_x, output logic got_ovf);
      int          w, p, guard, lat;
      logic [15:0] mask;
      logic [17:0] e;
      w     = an(k);
      p     = w / bl(k);
      mask  = 16'((32'd1 << w) - 1);
      va    = va & mask;
      vb    = vb & mask;
      e     = modelo(w, longint'(va), longint'(vb), vm);
      guard = 0;
      while (!in_ready[k] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_idle", {31'b0, in_ready[k]}, 32'd1);
      in_valid[k] = 1'b1;
      a_s[k]      = va;
      b_s[k]      = vb;
      modo[k]     = vm;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      a_s[k]      = 16'($urandom);
      b_s[k]      = 16'($urandom);
      modo[k]     = 1'($urandom);
      lat = 0;
      while (lat <= p + 4) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid[k]) break;
      end
      chk("latencia", 32'(lat), 32'(p));
      chk("x", {15'b0, x_s[k]}, {15'b0, e[16:0]});
      chk("desborde", {31'b0, desb[k]}, {31'b0, e[17]});
      got_x   = x_s[k];
      got_ovf = desb[k];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_x", {15'b0, x_s[k]}, {15'b0, e[16:0]});
         chk("hold_out_valid", {31'b0, out_valid[k]}, 32'd1);
         chk("hold_in_ready", {31'b0, in_ready[k]}, 32'd0);
      end
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
      @(negedge clk);
      chk("drain_out_valid", {31'b0, out_valid[k]}, 32'd0);
      chk("drain_in_ready", {31'b0, in_ready[k]}, 32'd1);
      chk("drain_x_kept", {15'b0, x_s[k]}, {15'b0, e[16:0]});
   endtask

   initial begin
      logic [16:0] gx;
      logic        gov;
      rst_n     = 1'b0;
      in_valid  = '0;
      modo      = '0;
      out_ready = '0;
      for (int k = 0; k < 4; k++) begin
         a_s[k] = '0;
         b_s[k] = '0;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("rst_out_valid", {31'b0, out_valid[k]}, 32'd0);
         chk("rst_x", {15'b0, x_s[k]}, 32'd0);
         chk("rst_desborde", {31'b0, desb[k]}, 32'd0);
         chk("rst_in_ready", {31'b0, in_ready[k]}, 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++)
         chk("post_rst_in_ready", {31'b0, in_ready[k]}, 32'd1);

      run_op(0, 16'd200, 16'd100, 1'b0, 0, gx, gov);
      chk("add_200_100", {15'b0, gx}, 32'h12C);
      chk("add_200_100_ovf", {31'b0, gov}, 32'd0);
      run_op(0, 16'd5, 16'd9, 1'b1, 0, gx, gov);
      chk("sub_5_9", {15'b0, gx}, 32'h1FC);
      chk("sub_5_9_ovf", {31'b0, gov}, 32'd0);
      run_op(0, 16'h7F, 16'h01, 1'b0, 0, gx, gov);
      chk("add_7F_01", {15'b0, gx}, 32'h080);
      chk("add_7F_01_ovf", {31'b0, gov}, 32'd1);
      run_op(0, 16'h80, 16'h01, 1'b1, 5, gx, gov);
      chk("sub_80_01_low", {24'b0, gx[7:0]}, 32'h7F);
      chk("sub_80_01_ovf", {31'b0, gov}, 32'd1);

      // Abort: reset sampled on the second computing edge.
      in_valid[0] = 1'b1;
      a_s[0]      = 16'd33;
      b_s[0]      = 16'd44;
      modo[0]     = 1'b0;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_out_valid", {31'b0, out_valid[0]}, 32'd0);
      chk("abort_x", {15'b0, x_s[0]}, 32'd0);
      chk("abort_in_ready", {31'b0, in_ready[0]}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("abort_no_result", {31'b0, out_valid[0]}, 32'd0);
      end
      chk("abort_in_ready_back", {31'b0, in_ready[0]}, 32'd1);

      for (int i = 0; i < 200; i++)
         run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2), gx, gov);
      for (int k = 1; k < 4; k++)
         for (int i = 0; i < 1000; i++)
            run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 1), gx, gov);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
